// File: rtl/grad_mag_engine.sv
// Per-element |Gx|, |Gy| and saturated L1 / approx-L2 magnitude over a ROWS x COLS window, LANES elements per beat.
// Latency: mag_done in the cycle after edge B=ceil(N/LANES) following the start edge; no backpressure, mag_en ignored while busy.
module grad_mag_engine #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int IN_W  = 9,
    parameter int OUT_W = 8,
    parameter int LANES = 4
) (
    input  logic                                    clk,
    input  logic                                    n_rst,
    input  logic                                    mag_en,
    input  logic                                    mode,
    input  logic [ROWS-1:0][COLS-1:0][IN_W-1:0]     x_in,
    input  logic [ROWS-1:0][COLS-1:0][IN_W-1:0]     y_in,
    output logic [ROWS-1:0][COLS-1:0][IN_W-1:0]     x_out,
    output logic [ROWS-1:0][COLS-1:0][IN_W-1:0]     y_out,
    output logic [ROWS-1:0][COLS-1:0][OUT_W-1:0]    mag_out,
    output logic                                    busy,
    output logic                                    mag_done
);

    localparam int N  = ROWS * COLS;
    localparam int B  = (N + LANES - 1) / LANES;
    localparam int IW = $clog2(B * LANES + 1);
    // Saturation limit widened to the IN_W+1 sum width; assumes OUT_W <= IN_W.
    localparam logic [IN_W:0] SAT = (IN_W + 1)'((1 << OUT_W) - 1);

    // CAPTURE is folded into the IDLE start edge; kept so busy decodes the full state set.
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                mode_q, mode_d;
    logic [N*IN_W-1:0]   x_sh_q, x_sh_d, y_sh_q, y_sh_d;
    logic [N*IN_W-1:0]   x_out_q, x_out_d, y_out_q, y_out_d;
    logic [N*OUT_W-1:0]  mag_q, mag_d;
    logic [IN_W-1:0]     ax, ay;
    int                  ei;

    // Read as unsigned, so the most negative input yields 2^(IN_W-1) with no wrap.
    function automatic logic [IN_W-1:0] abs_v(input logic [IN_W-1:0] v);
        return v[IN_W-1] ? (~v + IN_W'(1)) : v;
    endfunction

    function automatic logic [OUT_W-1:0] comb_mag(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                                                  input logic m);
        logic [IN_W:0] hi, lo, s;
        hi = (a >= b) ? {1'b0, a} : {1'b0, b};
        lo = (a >= b) ? {1'b0, b} : {1'b0, a};
        s  = m ? (hi + (lo >> 1)) : ({1'b0, a} + {1'b0, b});
        return (s > SAT) ? '1 : s[OUT_W-1:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        x_sh_d   = x_sh_q;
        y_sh_d   = y_sh_q;
        x_out_d  = x_out_q;
        y_out_d  = y_out_q;
        mag_d    = mag_q;
        ax       = '0;
        ay       = '0;
        ei       = 0;
        case (state_q)
            S_IDLE: begin
                if (mag_en) begin
                    x_sh_d  = x_in;
                    y_sh_d  = y_in;
                    mode_d  = mode;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_CAPTURE: state_d = S_RUN;
            S_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    ei = int'(idx_q) + l;
                    if (ei < N) begin
                        ax = abs_v(x_sh_q[ei*IN_W +: IN_W]);
                        ay = abs_v(y_sh_q[ei*IN_W +: IN_W]);
                        x_out_d[ei*IN_W +: IN_W]  = ax;
                        y_out_d[ei*IN_W +: IN_W]  = ay;
                        mag_d[ei*OUT_W +: OUT_W]  = comb_mag(ax, ay, mode_q);
                    end
                end
                idx_d = idx_q + IW'(LANES);
                if (int'(idx_q) + LANES >= N) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            x_sh_q  <= '0;
            y_sh_q  <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            mag_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            x_sh_q  <= x_sh_d;
            y_sh_q  <= y_sh_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            mag_q   <= mag_d;
        end
    end

    assign x_out    = x_out_q;
    assign y_out    = y_out_q;
    assign mag_out  = mag_q;
    assign busy     = (state_q != S_IDLE);
    assign mag_done = (state_q == S_DONE);

endmodule

// File: tb/tb_grad_mag_engine.sv
// Bench for grad_mag_engine: default instance (LANES=4) and a LANES=3 instance share stimulus.
module tb_grad_mag_engine;

    logic clk = 1'b0;
    logic n_rst, mag_en, mode;
    logic [3:0][3:0][8:0] x_in, y_in, xa_o, ya_o, xb_o, yb_o;
    logic [3:0][3:0][7:0] ma_o, mb_o;
    logic busy_a, done_a, busy_b, done_b;

    int n_pass = 0;
    int n_tot  = 0;
    int cx[16], cy[16];
    bit cmode;
    int ex_x[16], ex_y[16], ex_m[16];

    typedef struct {
        int idx;
        int x;
        int y;
        bit md;
        int ex;
        int ey;
        int em;
    } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;

    grad_mag_engine dut_a (
        .clk(clk), .n_rst(n_rst), .mag_en(mag_en), .mode(mode),
        .x_in(x_in), .y_in(y_in), .x_out(xa_o), .y_out(ya_o), .mag_out(ma_o),
        .busy(busy_a), .mag_done(done_a)
    );

    grad_mag_engine #(.LANES(3)) dut_b (
        .clk(clk), .n_rst(n_rst), .mag_en(mag_en), .mode(mode),
        .x_in(x_in), .y_in(y_in), .x_out(xb_o), .y_out(yb_o), .mag_out(mb_o),
        .busy(busy_b), .mag_done(done_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: plain integer arithmetic straight from the norm definitions.
    function automatic int model_mag(input int x, input int y, input bit m);
        int a, b, s;
        a = iabs(x);
        b = iabs(y);
        if (!m) s = a + b;
        else    s = ((a > b) ? a : b) + ((a > b) ? b : a) / 2;
        return (s > 255) ? 255 : s;
    endfunction

    task automatic build_expect();
        for (int i = 0; i < 16; i++) begin
            ex_x[i] = iabs(cx[i]);
            ex_y[i] = iabs(cy[i]);
            ex_m[i] = model_mag(cx[i], cy[i], cmode);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 16; i++) begin
            x_in[i/4][i%4] = 9'(cx[i]);
            y_in[i/4][i%4] = 9'(cy[i]);
        end
        mode = cmode;
    endtask

    task automatic scramble();
        for (int i = 0; i < 16; i++) begin
            x_in[i/4][i%4] = 9'($urandom);
            y_in[i/4][i%4] = 9'($urandom);
        end
        mode = ~cmode;
    endtask

    task automatic rand_data(input bit m);
        for (int i = 0; i < 16; i++) begin
            cx[i] = int'($urandom_range(511)) - 256;
            cy[i] = int'($urandom_range(511)) - 256;
        end
        cmode = m;
    endtask

    task automatic check_dut(input string tag, input logic [3:0][3:0][8:0] xo,
                             input logic [3:0][3:0][8:0] yo, input logic [3:0][3:0][7:0] mo);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s el%0d {x,y,mag}", tag, i),
                int'({xo[i/4][i%4], yo[i/4][i%4], mo[i/4][i%4]}),
                (ex_x[i] << 17) | (ex_y[i] << 8) | ex_m[i]);
        end
    endtask

    // Called at a negedge with ex_* prepared; poke_c>0 raises mag_en with junk data in that cycle.
    task automatic run(input string tag, input int poke_c);
        int seen_a, at_a, seen_b, at_b;
        seen_a = 0; at_a = -1; seen_b = 0; at_b = -1;
        drive_inputs();
        mag_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        scramble();
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) chk({tag, " busy after start"}, int'({busy_a, busy_b}), 3);
            if (done_a) begin
                seen_a++; at_a = c;
                check_dut({tag, " A"}, xa_o, ya_o, ma_o);
            end
            if (done_b) begin
                seen_b++; at_b = c;
                check_dut({tag, " B"}, xb_o, yb_o, mb_o);
            end
            mag_en = (c == poke_c);
            if (c == poke_c) scramble();
            @(negedge clk);
        end
        mag_en = 1'b0;
        chk({tag, " A done pulses"}, seen_a, 1);
        chk({tag, " A done cycle"}, at_a, 5);
        chk({tag, " B done pulses"}, seen_b, 1);
        chk({tag, " B done cycle"}, at_b, 7);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int quiet;
        tbl[0] = '{0,   -1,   1, 1'b0,   1,   1,   2};
        tbl[1] = '{5,   -3,   3, 1'b0,   3,   3,   6};
        tbl[2] = '{9,  -255,  0, 1'b0, 255,   0, 255};
        tbl[3] = '{15, -256,  0, 1'b0, 256,   0, 255};
        tbl[4] = '{2,  -100, 40, 1'b1, 100,  40, 120};
        tbl[5] = '{7,    30, -30, 1'b1, 30,  30,  45};
        tbl[6] = '{12, -200, 200, 1'b1, 200, 200, 255};

        // Reset with nonzero inputs applied.
        n_rst = 1'b0; mag_en = 1'b0; cmode = 1'b0;
        scramble();
        repeat (2) @(negedge clk);
        chk("reset outputs", int'(|{xa_o, ya_o, ma_o, xb_o, yb_o, mb_o}), 0);
        chk("reset busy/done", int'({busy_a, done_a, busy_b, done_b}), 0);
        n_rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("idle quiet c%0d", c),
                int'(|{xa_o, ya_o, ma_o, xb_o, yb_o, mb_o, busy_a, done_a, busy_b, done_b}), 0);
        end

        // Directed table vectors, one run per mode.
        for (int md = 0; md < 2; md++) begin
            for (int i = 0; i < 16; i++) begin cx[i] = 0; cy[i] = 0; end
            cmode = md[0];
            for (int t = 0; t < 7; t++) if (tbl[t].md == cmode) begin
                cx[tbl[t].idx] = tbl[t].x;
                cy[tbl[t].idx] = tbl[t].y;
            end
            build_expect();
            for (int t = 0; t < 7; t++) if (tbl[t].md == cmode) begin
                ex_x[tbl[t].idx] = tbl[t].ex;
                ex_y[tbl[t].idx] = tbl[t].ey;
                ex_m[tbl[t].idx] = tbl[t].em;
            end
            run($sformatf("table m%0d", md), 0);
        end

        // Ramp x=-i, y=i.
        for (int i = 0; i < 16; i++) begin cx[i] = -i; cy[i] = i; end
        cmode = 1'b0;
        build_expect();
        run("ramp", 0);

        // mag_en pulsed with different data during beat 2 must be ignored.
        rand_data(1'b0);
        build_expect();
        run("poke", 2);

        // Reset during beat 2 aborts at once with no mag_done.
        rand_data(1'b1);
        drive_inputs();
        mag_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mag_en = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("midrun reset outputs", int'(|{xa_o, ya_o, ma_o, xb_o, yb_o, mb_o}), 0);
        chk("midrun reset busy/done", int'({busy_a, done_a, busy_b, done_b}), 0);
        @(negedge clk);
        n_rst = 1'b1;
        quiet = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            quiet += int'(done_a) + int'(done_b) + int'(busy_a) + int'(busy_b);
        end
        chk("no done after abort", quiet, 0);

        // Fresh random runs in both modes.
        for (int k = 0; k < 4; k++) begin
            rand_data(k[0]);
            build_expect();
            run($sformatf("rand%0d", k), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
